// File: rtl/voice_cmd_if.sv
// voice_cmd_if: note-on/note-off command channel with valid/ready handshake
interface voice_cmd_if #(
  parameter int NOTE_BITS = 7,
  parameter int VEL_BITS  = 32
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_on;
  logic [NOTE_BITS-1:0] cmd_note;
  logic [VEL_BITS-1:0]  cmd_velocity;
  modport master (output cmd_valid, cmd_on, cmd_note, cmd_velocity, input cmd_ready);
  modport slave  (input cmd_valid, cmd_on, cmd_note, cmd_velocity, output cmd_ready);
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note-to-voice allocator with oldest-voice stealing
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_BITS  = 7,
  parameter int VEL_BITS   = 32,
  parameter int AGE_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  voice_cmd_if.slave                     cmd,
  input  logic [NUM_VOICES-1:0]          voice_available,
  output logic [NUM_VOICES-1:0]          voice_note_en,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic [NUM_VOICES*VEL_BITS-1:0] voice_velocity,
  output logic                           steal
);
  localparam int IW = $clog2(NUM_VOICES);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RELAUNCH} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  on_q, on_d;
  logic [NOTE_BITS-1:0]  cnote_q, cnote_d;
  logic [VEL_BITS-1:0]   cvel_q, cvel_d;
  logic                  mf_q, mf_d, ff_q, ff_d, of_q, of_d;
  logic [IW-1:0]         mi_q, mi_d, fi_q, fi_d, oi_q, oi_d;
  logic [AGE_BITS-1:0]   oa_q, oa_d;
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [NOTE_BITS-1:0]  note_q [NUM_VOICES];
  logic [NOTE_BITS-1:0]  note_d [NUM_VOICES];
  logic [VEL_BITS-1:0]   vel_q [NUM_VOICES];
  logic [VEL_BITS-1:0]   vel_d [NUM_VOICES];
  logic [AGE_BITS-1:0]   age_q [NUM_VOICES];
  logic [AGE_BITS-1:0]   age_d [NUM_VOICES];
  logic                  steal_q, steal_d, ready_q, ready_d;
  logic                  hit;
  logic [IW-1:0]         sel;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    on_d    = on_q;
    cnote_d = cnote_q;
    cvel_d  = cvel_q;
    mf_d    = mf_q;
    ff_d    = ff_q;
    of_d    = of_q;
    mi_d    = mi_q;
    fi_d    = fi_q;
    oi_d    = oi_q;
    oa_d    = oa_q;
    en_d    = en_q;
    note_d  = note_q;
    vel_d   = vel_q;
    steal_d = 1'b0;
    hit     = 1'b0;
    sel     = '0;
    if (state_q == IDLE && cmd.cmd_valid) begin
      on_d    = cmd.cmd_on;
      cnote_d = cmd.cmd_note;
      cvel_d  = cmd.cmd_velocity;
      {mf_d, ff_d, of_d} = '0;
      oa_d    = '0;
      idx_d   = '0;
      state_d = SCAN;
    end
    if (state_q == SCAN) begin
      if (!mf_q && en_q[idx_q] && note_q[idx_q] == cnote_q) begin
        mf_d = 1'b1;
        mi_d = idx_q;
      end
      if (!ff_q && voice_available[idx_q] && !en_q[idx_q]) begin
        ff_d = 1'b1;
        fi_d = idx_q;
      end
      // strict compare keeps the lowest index on equal ages
      if (!voice_available[idx_q] && (!of_q || age_q[idx_q] > oa_q)) begin
        of_d = 1'b1;
        oi_d = idx_q;
        oa_d = age_q[idx_q];
      end
      idx_d   = idx_q + 1'b1;
      state_d = (idx_q == IW'(NUM_VOICES - 1)) ? COMMIT : SCAN;
    end
    if (state_q == COMMIT) begin
      state_d = IDLE;
      if (on_q && mf_q) begin
        vel_d[mi_q] = cvel_q;
        hit = 1'b1;
        sel = mi_q;
      end else if (on_q && ff_q) begin
        note_d[fi_q] = cnote_q;
        vel_d[fi_q]  = cvel_q;
        en_d[fi_q]   = 1'b1;
        hit = 1'b1;
        sel = fi_q;
      end else if (on_q && of_q) begin
        note_d[oi_q] = cnote_q;
        vel_d[oi_q]  = cvel_q;
        en_d[oi_q]   = 1'b0;
        steal_d = 1'b1;
        hit = 1'b1;
        sel = oi_q;
        state_d = RELAUNCH;
      end else if (!on_q && mf_q) begin
        en_d[mi_q] = 1'b0;
      end
    end
    if (state_q == RELAUNCH) begin
      en_d[oi_q] = 1'b1;
      state_d = IDLE;
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      age_d[i] = age_q[i];
      if ((hit && IW'(i) == sel) || (voice_available[i] && !en_q[i]))
        age_d[i] = '0;
      else if (hit && !voice_available[i] && age_q[i] != '1)
        age_d[i] = age_q[i] + 1'b1;
    end
    ready_d = (state_d == IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      on_q    <= 1'b0;
      cnote_q <= '0;
      cvel_q  <= '0;
      {mf_q, ff_q, of_q} <= '0;
      mi_q    <= '0;
      fi_q    <= '0;
      oi_q    <= '0;
      oa_q    <= '0;
      en_q    <= '0;
      note_q  <= '{default: '0};
      vel_q   <= '{default: '0};
      age_q   <= '{default: '0};
      steal_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      on_q    <= on_d;
      cnote_q <= cnote_d;
      cvel_q  <= cvel_d;
      {mf_q, ff_q, of_q} <= {mf_d, ff_d, of_d};
      mi_q    <= mi_d;
      fi_q    <= fi_d;
      oi_q    <= oi_d;
      oa_q    <= oa_d;
      en_q    <= en_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
      age_q   <= age_d;
      steal_q <= steal_d;
      ready_q <= ready_d;
    end
  end
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_out
    assign voice_note[i*NOTE_BITS +: NOTE_BITS]  = note_q[i];
    assign voice_velocity[i*VEL_BITS +: VEL_BITS] = vel_q[i];
  end
  assign voice_note_en = en_q;
  assign steal         = steal_q;
  assign cmd.cmd_ready = ready_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: scoreboard-driven bench for the 4-voice allocator
module tb_voice_allocator;
  localparam int NV = 4, NB = 7, VB = 32, AB = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NV-1:0]    avail = '1;
  logic [NV-1:0]    en;
  logic [NV*NB-1:0] notes;
  logic [NV*VB-1:0] vels;
  logic             steal;
  int errors = 0, checks = 0;
  typedef struct {
    logic [NV-1:0] en;
    int            v;
    logic [NB-1:0] note;
    logic [VB-1:0] vel;
    logic          steal;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  voice_cmd_if #(.NOTE_BITS(NB), .VEL_BITS(VB)) cmd ();
  voice_allocator #(.NUM_VOICES(NV), .NOTE_BITS(NB), .VEL_BITS(VB), .AGE_BITS(AB)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .voice_available(avail), .voice_note_en(en),
    .voice_note(notes), .voice_velocity(vels), .steal(steal)
  );
  always #5 clk = ~clk;
  function automatic logic [NB-1:0] note_of(int v); return notes[v*NB +: NB]; endfunction
  function automatic logic [VB-1:0] vel_of(int v); return vels[v*VB +: VB]; endfunction
  task automatic tick(int n); repeat (n) @(posedge clk); #1; endtask
  task automatic do_reset;
    cmd.cmd_valid = 1'b0; cmd.cmd_on = 1'b0; cmd.cmd_note = '0; cmd.cmd_velocity = '0;
    avail = '1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask
  task automatic send(input logic on, input logic [NB-1:0] n, input logic [VB-1:0] v);
    int k = 0;
    while (!cmd.cmd_ready && k < 50) begin tick(1); k++; end
    checks++;
    if (cmd.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL send_ready: cmd_ready=%b required 1 within 50 cycles", cmd.cmd_ready);
    end
    cmd.cmd_valid = 1'b1; cmd.cmd_on = on; cmd.cmd_note = n; cmd.cmd_velocity = v;
    tick(1);
    cmd.cmd_valid = 1'b0;
  endtask
  task automatic test_reset;
    do_reset();
    checks += 4;
    if (en !== '0) begin errors++; $display("FAIL reset_en: got %b required 0", en); end
    if (notes !== '0 || vels !== '0) begin errors++; $display("FAIL reset_regs: note=%h vel=%h required 0", notes, vels); end
    if (steal !== 1'b0) begin errors++; $display("FAIL reset_steal: got %b required 0", steal); end
    if (cmd.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", cmd.cmd_ready); end
  endtask
  task automatic test_note_on;
    do_reset();
    sb.push_back('{4'b0001, 0, 7'd60, 32'h100, 1'b0});
    send(1'b1, 7'd60, 32'h100);
    tick(4);
    checks++;
    if (en !== '0) begin errors++; $display("FAIL on_early: en=%b required 0000 before commit", en); end
    tick(1);
    e = sb.pop_front();
    checks += 4;
    if (en !== e.en) begin errors++; $display("FAIL on_en: got %b required %b", en, e.en); end
    if (note_of(e.v) !== e.note) begin errors++; $display("FAIL on_note: got %0d required %0d", note_of(e.v), e.note); end
    if (vel_of(e.v) !== e.vel) begin errors++; $display("FAIL on_vel: got %h required %h", vel_of(e.v), e.vel); end
    if (steal !== e.steal) begin errors++; $display("FAIL on_steal: got %b required %b", steal, e.steal); end
  endtask
  task automatic test_note_off;
    logic [NB-1:0] n [3] = '{7'd60, 7'd64, 7'd67};
    logic [NV-1:0] m [3] = '{4'b0001, 4'b0011, 4'b0111};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{m[i], i, n[i], 32'h10 * (i + 1), 1'b0});
      send(1'b1, n[i], 32'h10 * (i + 1));
      tick(5);
      e = sb.pop_front();
      checks += 2;
      if (en !== e.en) begin errors++; $display("FAIL fill_en%0d: got %b required %b", i, en, e.en); end
      if (note_of(e.v) !== e.note) begin errors++; $display("FAIL fill_note%0d: got %0d required %0d", i, note_of(e.v), e.note); end
      avail = avail & ~en;
    end
    sb.push_back('{4'b0101, 1, 7'd64, 32'h20, 1'b0});
    send(1'b0, 7'd64, '0);
    tick(4);
    checks++;
    if (en !== 4'b0111) begin errors++; $display("FAIL off_early: en=%b required 0111", en); end
    tick(1);
    e = sb.pop_front();
    checks += 3;
    if (en !== e.en) begin errors++; $display("FAIL off_en: got %b required %b", en, e.en); end
    if (note_of(e.v) !== e.note) begin errors++; $display("FAIL off_note: got %0d required %0d", note_of(e.v), e.note); end
    if (vel_of(e.v) !== e.vel) begin errors++; $display("FAIL off_vel: got %h required %h", vel_of(e.v), e.vel); end
  endtask
  task automatic test_retrigger;
    do_reset();
    send(1'b1, 7'd60, 32'h100);
    tick(5);
    avail = avail & ~en;
    sb.push_back('{4'b0001, 0, 7'd60, 32'h200, 1'b0});
    send(1'b1, 7'd60, 32'h200);
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      checks++;
      if (en !== 4'b0001 || steal !== 1'b0) begin
        errors++; $display("FAIL retrig_gate%0d: en=%b steal=%b required 0001/0", c, en, steal);
      end
    end
    e = sb.pop_front();
    checks += 2;
    if (vel_of(e.v) !== e.vel) begin errors++; $display("FAIL retrig_vel: got %h required %h", vel_of(e.v), e.vel); end
    if (note_of(e.v) !== e.note) begin errors++; $display("FAIL retrig_note: got %0d required %0d", note_of(e.v), e.note); end
  endtask
  task automatic test_steal;
    logic [NB-1:0] n [4] = '{7'd60, 7'd62, 7'd64, 7'd65};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, n[i], 32'h1);
      tick(5);
      avail = avail & ~en;
    end
    checks++;
    if (en !== 4'b1111) begin errors++; $display("FAIL steal_fill: en=%b required 1111", en); end
    sb.push_back('{4'b1110, 0, 7'd70, 32'h777, 1'b1});
    send(1'b1, 7'd70, 32'h777);
    tick(4);
    checks++;
    if (en !== 4'b1111 || steal !== 1'b0) begin errors++; $display("FAIL steal_early: en=%b steal=%b required 1111/0", en, steal); end
    tick(1);
    e = sb.pop_front();
    checks += 4;
    if (en !== e.en) begin errors++; $display("FAIL steal_fall: en=%b required %b", en, e.en); end
    if (steal !== e.steal) begin errors++; $display("FAIL steal_pulse: got %b required %b", steal, e.steal); end
    if (note_of(e.v) !== e.note) begin errors++; $display("FAIL steal_note: got %0d required %0d", note_of(e.v), e.note); end
    if (vel_of(e.v) !== e.vel) begin errors++; $display("FAIL steal_vel: got %h required %h", vel_of(e.v), e.vel); end
    tick(1);
    checks += 2;
    if (en !== 4'b1111) begin errors++; $display("FAIL steal_rise: en=%b required 1111", en); end
    if (steal !== 1'b0) begin errors++; $display("FAIL steal_width: got %b required 0", steal); end
  endtask
  task automatic test_no_match;
    do_reset();
    sb.push_back('{4'b0000, 0, 7'd0, 32'h0, 1'b0});
    send(1'b0, 7'd99, '0);
    tick(4);
    checks++;
    if (cmd.cmd_ready !== 1'b0) begin errors++; $display("FAIL nomatch_busy: ready=%b required 0", cmd.cmd_ready); end
    tick(1);
    e = sb.pop_front();
    checks += 3;
    if (cmd.cmd_ready !== 1'b1) begin errors++; $display("FAIL nomatch_ready: ready=%b required 1", cmd.cmd_ready); end
    if (en !== e.en) begin errors++; $display("FAIL nomatch_en: got %b required %b", en, e.en); end
    if (notes !== '0) begin errors++; $display("FAIL nomatch_note: got %h required 0", notes); end
  endtask
  task automatic test_reset_mid_scan;
    do_reset();
    send(1'b1, 7'd60, 32'h100);
    tick(5);
    avail = avail & ~en;
    sb.push_back('{4'b0000, 0, 7'd0, 32'h0, 1'b0});
    send(1'b1, 7'd62, 32'h200);
    tick(2);
    rst = 1'b1;
    #1;
    e = sb.pop_front();
    checks += 3;
    if (en !== e.en) begin errors++; $display("FAIL rstscan_en: got %b required %b", en, e.en); end
    if (notes !== '0 || vels !== '0) begin errors++; $display("FAIL rstscan_regs: note=%h vel=%h required 0", notes, vels); end
    if (cmd.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstscan_ready: got %b required 1", cmd.cmd_ready); end
    tick(1);
    rst = 1'b0;
    avail = '1;
    tick(8);
    checks++;
    if (en !== '0) begin errors++; $display("FAIL rstscan_lost: en=%b required 0000", en); end
  endtask
  initial begin
    cmd.cmd_valid = 1'b0; cmd.cmd_on = 1'b0; cmd.cmd_note = '0; cmd.cmd_velocity = '0;
    test_reset();
    test_note_on();
    test_note_off();
    test_retrigger();
    test_steal();
    test_no_match();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
